// File: rtl/timer_ctrl28.sv
`default_nettype none
// ============================================================================
//  Module   : timer_ctrl28
//  Purpose  : Sequencing controller that turns the 28-bit nibble-chained
//             counter into a programmable interval timer. It latches a
//             terminal period, starts/stops/pauses counting, supports
//             one-shot and periodic (auto-reload) modes, and emits a
//             one-cycle tick at every terminal count.
//  Optional : Define TIMER_CTRL28_PRESCALE_EN to add a 4-bit prescaler and
//             the prescale[3:0] input. Without it the count steps on every
//             RUN cycle.
//  Ports    : clk        in   rising-edge clock
//             reset      in   asynchronous, active-low reset
//             prescale   in   [3:0] count-step divider minus one (option only)
//             load       in   write period_in (accepted in IDLE/DONE only)
//             period_in  in   [WIDTH-1:0] terminal count value
//             start      in   pulse, IDLE/DONE -> RUN
//             stop       in   pulse, any state -> IDLE
//             pause      in   level, holds RUN in PAUSE
//             periodic   in   mode sampled on an accepted start
//             count      out  [WIDTH-1:0] current count
//             tick       out  one-cycle pulse on terminal count
//             busy       out  high in RUN or PAUSE
//             done       out  high in DONE
//  Revision : 1.0  initial release
// ============================================================================
module timer_ctrl28 #(
   parameter int               WIDTH      = 28,  // multiple of 4 (nibble chain)
   parameter logic [WIDTH-1:0] RST_PERIOD = '1
) (
   input  logic             clk,
   input  logic             reset,
`ifdef TIMER_CTRL28_PRESCALE_EN
   input  logic [3:0]       prescale,
`endif
   input  logic             load,
   input  logic [WIDTH-1:0] period_in,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             periodic,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             step_en;
   logic             idle_or_done;

`ifdef TIMER_CTRL28_PRESCALE_EN
   logic [3:0]       presc_q, presc_d;

   // The count only advances on the edge where the prescaler has caught up
   // with the programmed divider.
   assign step_en = (presc_q == prescale);
`else
   assign step_en = 1'b1;
`endif

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      period_d = period_q;
      mode_d   = mode_q;
      tick_d   = 1'b0;
      busy_d   = busy_q;
      done_d   = done_q;
`ifdef TIMER_CTRL28_PRESCALE_EN
      presc_d  = presc_q;
`endif

      // Period writes are independent of the command decode, so a load on
      // the same edge as an accepted start governs the new run.
      if (load && idle_or_done) begin
         period_d = period_in;
      end

      if (stop) begin
         state_d = ST_IDLE;
         count_d = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
`ifdef TIMER_CTRL28_PRESCALE_EN
         presc_d = 4'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d = ST_RUN;
                  count_d = '0;
                  mode_d  = periodic;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
`ifdef TIMER_CTRL28_PRESCALE_EN
                  presc_d = 4'd0;
`endif
               end
            end

            // RUN and PAUSE share one decode: pause is a pure gate, so the
            // edge that leaves PAUSE also advances the count. The stall is
            // therefore exactly the number of cycles pause was high.
            ST_RUN, ST_PAUSE: begin
               if (pause) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_RUN;
`ifdef TIMER_CTRL28_PRESCALE_EN
                  presc_d = step_en ? 4'd0 : (presc_q + 4'd1);
`endif
                  if (step_en) begin
                     // Equality compare: count never passes period, so an
                     // all-ones period completes without overflow.
                     if (count_q == period_q) begin
                        tick_d = 1'b1;
                        if (mode_q) begin
                           count_d = '0;
                        end else begin
                           state_d = ST_DONE;
                           busy_d  = 1'b0;
                           done_d  = 1'b1;
                        end
                     end else begin
                        count_d = count_q + COUNT_ONE;
                     end
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               count_d = '0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         period_q <= RST_PERIOD;
         mode_q   <= 1'b0;
         tick_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         tick_q   <= tick_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef TIMER_CTRL28_PRESCALE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= 4'd0;
      end else begin
         presc_q <= presc_d;
      end
   end
`endif

   assign count = count_q;
   assign tick  = tick_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl28.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_ctrl28
//  Purpose  : Self-checking bench for timer_ctrl28: vector table, hand-built
//             multi-cycle sequences and randomized traffic against a
//             behavioural timer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_ctrl28;

   localparam int W = 28;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] period_in = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         pause = 1'b0;
   logic         periodic = 1'b0;
`ifdef TIMER_CTRL28_PRESCALE_EN
   logic [3:0]   prescale = 4'd0;
`endif
   logic [W-1:0] count;
   logic         tick;
   logic         busy;
   logic         done;

   int checks = 0;
   int failures = 0;

   timer_ctrl28 dut (
      .clk       (clk),
      .reset     (reset),
`ifdef TIMER_CTRL28_PRESCALE_EN
      .prescale  (prescale),
`endif
      .load      (load),
      .period_in (period_in),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .periodic  (periodic),
      .count     (count),
      .tick      (tick),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr;
      load = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic         ld;
      logic [W-1:0] pin;
      logic         st;
      logic         sp;
      logic         pa;
      logic         per;
      logic [W-1:0] e_cnt;
      logic         e_tick;
      logic         e_busy;
      logic         e_done;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic ld, int pin, logic st, logic sp, logic pa, logic per,
                               int cnt, logic tk, logic bs, logic dn);
      vec_t v;
      v.ld = ld; v.pin = W'(pin); v.st = st; v.sp = sp; v.pa = pa; v.per = per;
      v.e_cnt = W'(cnt); v.e_tick = tk; v.e_busy = bs; v.e_done = dn;
      return v;
   endfunction

   // ------------------------------------------------------- reference model
   int unsigned m_count, m_period;
   int          m_pre;
   bit          m_active, m_done, m_per, m_tick;

   task automatic model_step(input bit ld, input int unsigned pin, input bit st, input bit sp,
                             input bit pa, input bit per, input int ps);
      bit was_active;
      was_active = m_active;
      m_tick = 1'b0;
      if (ld && !was_active) m_period = pin;
      if (sp) begin
         m_active = 1'b0; m_done = 1'b0; m_count = 0; m_pre = 0;
      end else if (!was_active) begin
         if (st) begin
            m_active = 1'b1; m_done = 1'b0; m_count = 0; m_per = per; m_pre = 0;
         end
      end else if (!pa) begin
         if (m_pre == ps) begin
            m_pre = 0;
            if (m_count == m_period) begin
               m_tick = 1'b1;
               if (m_per) m_count = 0;
               else begin
                  m_active = 1'b0;
                  m_done = 1'b1;
               end
            end else begin
               m_count = m_count + 1;
            end
         end else begin
            m_pre = m_pre + 1;
         end
      end
   endtask

   initial begin
      int first_tick;
      int ps;

      // ------------------------------------------------ reset values, no clock
      #1;
      chk("reset count", count, 0);
      chk("reset busy", busy, 0);
      chk("reset tick", tick, 0);
      chk("reset done", done, 0);
      @(negedge clk);
      reset = 1'b1;

      // --------------------------------------- asynchronous reset mid-run
      start = 1'b1; periodic = 1'b1;
      step;
      clr;
      for (int k = 1; k <= 5; k++) step;
      chk("pre-reset count", count, 5);
      #3 reset = 1'b0;
      #1;
      chk("async reset count", count, 0);
      chk("async reset busy", busy, 0);
      chk("async reset tick", tick, 0);
      chk("async reset done", done, 0);
      #2 reset = 1'b1;
      @(negedge clk);

      // ------------- reset period is all ones: a short run never ticks
      start = 1'b1; periodic = 1'b1;
      step;
      clr;
      chk("rst-period start count", count, 0);
      load = 1'b1; period_in = W'(1);
      for (int k = 1; k <= 3; k++) begin
         step;
         clr;
         chk($sformatf("rst-period count%0d", k), count, k);
         chk($sformatf("rst-period tick%0d", k), tick, 0);
      end
      stop = 1'b1;
      step;
      clr;

      // --------------------------------------------------------- vector table
      vt.push_back(mk(1,3,0,0,0,0, 0,0,0,0));   // load 3
      vt.push_back(mk(0,0,1,0,0,0, 0,0,1,0));   // one-shot start
      vt.push_back(mk(0,0,0,0,0,0, 1,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 3,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 3,1,0,1));   // terminal: tick, done
      vt.push_back(mk(0,0,0,0,0,0, 3,0,0,1));   // count holds period
      vt.push_back(mk(1,2,0,0,0,0, 3,0,0,1));   // load 2 in DONE
      vt.push_back(mk(0,0,1,0,0,1, 0,0,1,0));   // periodic start
      vt.push_back(mk(0,0,0,0,0,0, 1,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 0,1,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 1,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 0,1,1,0));
      vt.push_back(mk(0,0,0,1,0,0, 0,0,0,0));   // stop
      vt.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
      vt.push_back(mk(0,0,1,0,0,1, 0,0,1,0));   // periodic start, period 2
      vt.push_back(mk(1,7,0,0,0,0, 1,0,1,0));   // load while busy ignored
      vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0, 0,1,1,0));   // still period 2
      vt.push_back(mk(0,0,1,1,0,1, 0,0,0,0));   // stop+start -> IDLE
      vt.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
      vt.push_back(mk(1,0,1,0,0,1, 0,0,1,0));   // load 0 + periodic start
      vt.push_back(mk(0,0,0,0,0,0, 0,1,1,0));   // tick every cycle
      vt.push_back(mk(0,0,0,0,0,0, 0,1,1,0));
      vt.push_back(mk(0,0,0,1,0,0, 0,0,0,0));
      vt.push_back(mk(0,0,1,0,0,0, 0,0,1,0));   // one-shot, period 0
      vt.push_back(mk(0,0,0,0,0,0, 0,1,0,1));
      vt.push_back(mk(0,0,0,0,0,0, 0,0,0,1));

      foreach (vt[i]) begin
         load = vt[i].ld; period_in = vt[i].pin; start = vt[i].st;
         stop = vt[i].sp; pause = vt[i].pa; periodic = vt[i].per;
         step;
         chk($sformatf("vec%0d count", i), count, vt[i].e_cnt);
         chk($sformatf("vec%0d tick", i), tick, vt[i].e_tick);
         chk($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
         chk($sformatf("vec%0d done", i), done, vt[i].e_done);
      end
      clr;

      // ------------------------- load 7 + start in DONE: tick 8 edges later
      load = 1'b1; period_in = W'(7); start = 1'b1; periodic = 1'b0;
      step;
      clr;
      chk("ld+start count", count, 0);
      chk("ld+start busy", busy, 1);
      chk("ld+start done", done, 0);
      first_tick = -1;
      for (int n = 1; n <= 20; n++) begin
         step;
         if (tick && first_tick < 0) first_tick = n;
         if (first_tick >= 0) break;
      end
      chk("ld+start tick edge", first_tick, 8);
      chk("ld+start final count", count, 7);
      chk("ld+start final done", done, 1);

      // ------------------------------------- pause defers first tick by 5
      stop = 1'b1; step; clr;
      load = 1'b1; period_in = W'(10); step; clr;
      start = 1'b1; periodic = 1'b1; step; clr;
      first_tick = -1;
      for (int n = 1; n <= 30; n++) begin
         pause = (n >= 5 && n <= 9);
         step;
         if (n == 9) begin
            chk("pause frozen count", count, 4);
            chk("pause busy", busy, 1);
         end
         if (tick && first_tick < 0) first_tick = n;
      end
      pause = 1'b0;
      chk("pause first tick edge", first_tick, 16);

`ifdef TIMER_CTRL28_PRESCALE_EN
      // ------------------------------------------ prescale 3, period 1
      stop = 1'b1; step; clr;
      load = 1'b1; period_in = W'(1); step; clr;
      prescale = 4'd3;
      start = 1'b1; periodic = 1'b1; step; clr;
      for (int n = 1; n <= 16; n++) begin
         step;
         chk($sformatf("presc count n%0d", n), count, ((n / 4) % 2));
         chk($sformatf("presc tick n%0d", n), tick, (n % 8 == 0) ? 1 : 0);
      end
      prescale = 4'd0;
`endif

      // ---------------------------------------- randomized vs. model
      stop = 1'b1; step; clr;
      load = 1'b1; period_in = W'(4); step; clr;
      m_count = 0; m_period = 4; m_pre = 0;
      m_active = 1'b0; m_done = 1'b0; m_per = 1'b0; m_tick = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         load      = ($urandom_range(0, 5) == 0);
         period_in = W'($urandom_range(0, 9));
         start     = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 39) == 0);
         pause     = ($urandom_range(0, 5) == 0);
         periodic  = 1'($urandom_range(0, 1));
         ps = 0;
`ifdef TIMER_CTRL28_PRESCALE_EN
         if ($urandom_range(0, 49) == 0) prescale = 4'($urandom_range(0, 2));
         ps = int'(prescale);
`endif
         model_step(load, int'(period_in), start, stop, pause, periodic, ps);
         step;
         chk($sformatf("rand%0d {count,tick,busy,done}", c),
             {count, tick, busy, done},
             {W'(m_count), m_tick, m_active, m_done});
      end
      clr;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
